alu_arbiter: RTL and testbench

Shares one combinational `alu` instance between two requesters. Each requester submits operand/control transactions over a valid/ready handshake. The block grants them round-robin, registers the operands and drives the ALU for one execute cycle. It then captures result and flags into a response register and returns them on the granted requester's response channel. It sits between the register-file/decode logic of two issuing units and the single shared 32-bit ALU.

---
 rtl/alu_types.sv | 18 +
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_types.sv
// Shared ALU operation encoding used by the arbiter, the ALU and
// its requesters. Encoding 0 (ADD) is the reset value of the ALU input.
package alu_types_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_control_t;

endpackage

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// Ports: clk/rst; req0/req1 valid/ready + a/b/control; rsp0/rsp1
// valid/ready + result/overflow/zero/equal; alu_a/alu_b/alu_control out
// to the ALU, alu_result/alu_overflow/alu_zero/alu_equal back from it.
module alu_arbiter
   import alu_types_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  alu_control_t req0_control,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  alu_control_t req1_control,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic [N-1:0] rsp0_result,
   output logic         rsp0_overflow,
   output logic         rsp0_zero,
   output logic         rsp0_equal,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [N-1:0] rsp1_result,
   output logic         rsp1_overflow,
   output logic         rsp1_zero,
   output logic         rsp1_equal,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output alu_control_t alu_control,
   input  logic [N-1:0] alu_result,
   input  logic         alu_overflow,
   input  logic         alu_zero,
   input  logic         alu_equal
);

   typedef enum logic [1:0] {IDLE, EXECUTE, RESPOND} state_t;

   state_t       state_q, state_d;
   logic         prio_q, prio_d;
   logic         owner_q, owner_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   alu_control_t ctrl_q, ctrl_d;
   // Per-port response registers: the non-owner keeps its old data.
   logic [N-1:0] res0_q, res0_d;
   logic [N-1:0] res1_q, res1_d;
   logic [2:0]   flg0_q, flg0_d;
   logic [2:0]   flg1_q, flg1_d;

   logic gnt0, gnt1, accept, rsp_hs;

   // prio only breaks ties; a lone requester always wins.
   assign gnt0 = req0_valid & (~req1_valid | ~prio_q);
   assign gnt1 = req1_valid & (~req0_valid | prio_q);

   assign req0_ready = (state_q == IDLE) & gnt0;
   assign req1_ready = (state_q == IDLE) & gnt1;

   assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   assign rsp_hs = owner_q ? rsp1_ready : rsp0_ready;

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      owner_d = owner_q;
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      res0_d  = res0_q;
      res1_d  = res1_q;
      flg0_d  = flg0_q;
      flg1_d  = flg1_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EXECUTE;
               owner_d = req1_ready;
               prio_d  = ~req1_ready;
               a_d     = req1_ready ? req1_a : req0_a;
               b_d     = req1_ready ? req1_b : req0_b;
               ctrl_d  = req1_ready ? req1_control : req0_control;
            end
         end
         EXECUTE: begin
            state_d = RESPOND;
            if (owner_q) begin
               res1_d = alu_result;
               flg1_d = {alu_overflow, alu_zero, alu_equal};
            end else begin
               res0_d = alu_result;
               flg0_d = {alu_overflow, alu_zero, alu_equal};
            end
         end
         RESPOND: begin
            if (rsp_hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= alu_control_t'('0);
         res0_q  <= '0;
         res1_q  <= '0;
         flg0_q  <= '0;
         flg1_q  <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         res0_q  <= res0_d;
         res1_q  <= res1_d;
         flg0_q  <= flg0_d;
         flg1_q  <= flg1_d;
      end
   end

   // Valid decodes straight from state so reset drops it at once.
   assign rsp0_valid = (state_q == RESPOND) & ~owner_q;
   assign rsp1_valid = (state_q == RESPOND) & owner_q;

   assign rsp0_result = res0_q;
   assign rsp1_result = res1_q;
   assign {rsp0_overflow, rsp0_zero, rsp0_equal} = flg0_q;
   assign {rsp1_overflow, rsp1_zero, rsp1_equal} = flg1_q;

   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_control = ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random bench for alu_arbiter with a behavioural ALU.
module tb_alu_arbiter;
   import alu_types_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0]  req0_a, req0_b, req1_a, req1_b;
   alu_control_t req0_control, req1_control;
   logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0]  rsp0_result, rsp1_result;
   logic         rsp0_overflow, rsp0_zero, rsp0_equal;
   logic         rsp1_overflow, rsp1_zero, rsp1_equal;
   logic [31:0]  alu_a, alu_b, alu_result;
   alu_control_t alu_control;
   logic         alu_overflow, alu_zero, alu_equal;

   int checks   = 0;
   int failures = 0;
   int both_hi  = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.N(32)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_control(req0_control),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_control(req1_control),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_result(rsp0_result), .rsp0_overflow(rsp0_overflow),
      .rsp0_zero(rsp0_zero), .rsp0_equal(rsp0_equal),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_result(rsp1_result), .rsp1_overflow(rsp1_overflow),
      .rsp1_zero(rsp1_zero), .rsp1_equal(rsp1_equal),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_result(alu_result), .alu_overflow(alu_overflow),
      .alu_zero(alu_zero), .alu_equal(alu_equal)
   );

   // Returns {overflow, zero, equal, result}.
   function automatic logic [34:0] alu_behavioural(
      input logic [31:0] a, input logic [31:0] b, input alu_control_t c);
      logic [31:0] r;
      logic        v;
      v = 1'b0;
      case (c)
         ALU_ADD: begin
            r = a + b;
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         ALU_SUB: begin
            r = a - b;
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_SLL:  r = a << b[4:0];
         ALU_SRL:  r = a >> b[4:0];
         ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
         ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: r = {31'd0, a < b};
         default:  r = 32'd0;
      endcase
      return {v, r == 32'd0, a == b, r};
   endfunction

   always_comb begin
      {alu_overflow, alu_zero, alu_equal, alu_result} =
         alu_behavioural(alu_a, alu_b, alu_control);
   end

   always @(negedge clk) begin
      if (req0_ready && req1_ready) both_hi++;
   end

   task automatic apply_reset();
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0;
      req0_a = 0; req0_b = 0; req0_control = ALU_ADD;
      req1_a = 0; req1_b = 0; req1_control = ALU_ADD;
      rsp0_ready = 1; rsp1_ready = 1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      rst = 1'b1;
      req1_valid = 1;
      #1;
      checks++;
      if ({rsp0_valid, rsp1_valid, alu_a, alu_b, alu_control} !== 70'd0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b%b a=%h b=%h c=%0d want zeros",
                  rsp0_valid, rsp1_valid, alu_a, alu_b, alu_control);
      end
      checks++;
      if ({rsp0_result, rsp1_result, rsp0_overflow, rsp0_zero,
           rsp0_equal, rsp1_overflow, rsp1_zero, rsp1_equal} !== 70'd0) begin
         failures++;
         $display("FAIL reset_rsp_data got r0=%h r1=%h want 0",
                  rsp0_result, rsp1_result);
      end
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         failures++;
         $display("FAIL reset_ready got %b%b want 01", req0_ready, req1_ready);
      end
      req1_valid = 0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single_add();
      apply_reset();
      req0_valid = 1; req0_a = 5; req0_b = 7; req0_control = ALU_ADD;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL add_ready got %b%b want 10", req0_ready, req1_ready);
      end
      @(posedge clk);
      #1 req0_valid = 0;
      #1;
      checks++;
      if (rsp0_valid !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
         failures++;
         $display("FAIL add_execute got v=%b a=%0d b=%0d want v=0 a=5 b=7",
                  rsp0_valid, alu_a, alu_b);
      end
      @(posedge clk);
      #2;
      checks++;
      if ({rsp0_valid, rsp1_valid, rsp0_result, rsp0_zero, rsp0_equal}
          !== {2'b10, 32'd12, 2'b00}) begin
         failures++;
         $display("FAIL add_response got v=%b%b r=%0d z=%b e=%b want v=10 r=12 z=0 e=0",
                  rsp0_valid, rsp1_valid, rsp0_result, rsp0_zero, rsp0_equal);
      end
      @(posedge clk);
      #2;
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
         failures++;
         $display("FAIL add_done got v=%b%b want 00", rsp0_valid, rsp1_valid);
      end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      both_hi = 0;
      req0_valid = 1; req0_a = 1; req0_b = 1; req0_control = ALU_ADD;
      req1_valid = 1; req1_a = 9; req1_b = 4; req1_control = ALU_SUB;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         failures++;
         $display("FAIL sim_first_grant got %b%b want 10", req0_ready, req1_ready);
      end
      @(posedge clk);
      #1 req0_valid = 0;
      @(posedge clk);
      #2;
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd2) begin
         failures++;
         $display("FAIL sim_rsp0 got v=%b r=%0d want v=1 r=2", rsp0_valid, rsp0_result);
      end
      @(posedge clk);
      #2;
      checks++;
      if (req1_ready !== 1'b1) begin
         failures++;
         $display("FAIL sim_second_grant got %b want 1", req1_ready);
      end
      @(posedge clk);
      #1 req1_valid = 0;
      @(posedge clk);
      #2;
      checks++;
      if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_result !== 32'd5) begin
         failures++;
         $display("FAIL sim_rsp1 got v=%b%b r=%0d want v=01 r=5",
                  rsp0_valid, rsp1_valid, rsp1_result);
      end
      checks++;
      if (both_hi !== 0) begin
         failures++;
         $display("FAIL sim_both_ready got %0d cycles want 0", both_hi);
      end
   endtask

   task automatic test_fairness();
      int n, last, port;
      apply_reset();
      both_hi = 0;
      n = 0; last = 0;
      req0_valid = 1; req0_a = 3; req0_b = 2; req0_control = ALU_ADD;
      req1_valid = 1; req1_a = 3; req1_b = 2; req1_control = ALU_SUB;
      for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
         #1;
         if (req0_ready || req1_ready) begin
            port = req1_ready ? 1 : 0;
            checks++;
            if (port != (n % 2)) begin
               failures++;
               $display("FAIL fair_order txn %0d got port %0d want %0d", n, port, n % 2);
            end
            if (n > 0) begin
               checks++;
               if (cyc - last != 3) begin
                  failures++;
                  $display("FAIL fair_gap txn %0d got %0d cycles want 3", n, cyc - last);
               end
            end
            last = cyc;
            n++;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (n != 6 || both_hi != 0) begin
         failures++;
         $display("FAIL fair_count got %0d grants both=%0d want 6 both=0", n, both_hi);
      end
      req0_valid = 0; req1_valid = 0;
   endtask

   task automatic test_backpressure();
      apply_reset();
      req1_valid = 1; req1_a = 32'h10; req1_b = 32'h10; req1_control = ALU_SUB;
      rsp1_ready = 0;
      #1;
      checks++;
      if (req1_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_grant got %b want 1", req1_ready);
      end
      @(posedge clk);
      #1 req1_valid = 0; req0_valid = 1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if ({rsp1_valid, rsp1_result, rsp1_overflow, rsp1_zero, rsp1_equal,
              req0_ready} !== {1'b1, 32'd0, 3'b011, 1'b0}) begin
            failures++;
            $display("FAIL bp_hold cycle %0d got v=%b r=%h o=%b z=%b e=%b rdy0=%b want 1 0 0 1 1 0",
                     k, rsp1_valid, rsp1_result, rsp1_overflow, rsp1_zero,
                     rsp1_equal, req0_ready);
         end
         @(posedge clk);
         #1;
      end
      rsp1_ready = 1;
      @(posedge clk);
      #2;
      checks++;
      if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release got v=%b rdy0=%b want 0 1", rsp1_valid, req0_ready);
      end
      req0_valid = 0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req0_valid = 1; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
      req0_control = ALU_AND;
      @(posedge clk);
      #1 req0_valid = 0;
      #1;
      checks++;
      if (alu_a !== 32'hFFFF0000 || alu_control !== ALU_AND) begin
         failures++;
         $display("FAIL mid_execute got a=%h c=%0d want ffff0000 2", alu_a, alu_control);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({rsp0_valid, rsp1_valid, alu_a, alu_b, alu_control, rsp0_result} !== 102'd0) begin
         failures++;
         $display("FAIL mid_reset got v=%b%b a=%h b=%h c=%0d r0=%h want zeros",
                  rsp0_valid, rsp1_valid, alu_a, alu_b, alu_control, rsp0_result);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      req0_valid = 1; req0_a = 3; req0_b = 4; req0_control = ALU_OR;
      req1_valid = 1; req1_a = 1; req1_b = 1; req1_control = ALU_ADD;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         failures++;
         $display("FAIL mid_prio got %b%b want 10", req0_ready, req1_ready);
      end
      @(posedge clk);
      #1 req0_valid = 0; req1_valid = 0;
      @(posedge clk);
      #2;
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd7) begin
         failures++;
         $display("FAIL mid_after got v=%b r=%0d want v=1 r=7", rsp0_valid, rsp0_result);
      end
   endtask

   task automatic test_random();
      int sent0, sent1, got0, got1, cyc;
      logic [34:0] exp0, exp1;
      logic pend0, pend1, acc0, acc1;
      apply_reset();
      sent0 = 0; sent1 = 0; got0 = 0; got1 = 0; cyc = 0;
      pend0 = 0; pend1 = 0; exp0 = '0; exp1 = '0;
      req0_valid = 1; req0_a = $urandom; req0_b = $urandom;
      req0_control = alu_control_t'(4'($urandom_range(0, 9)));
      req1_valid = 1; req1_a = $urandom; req1_b = req1_a;
      req1_control = alu_control_t'(4'($urandom_range(0, 9)));
      while ((got0 < 25 || got1 < 25) && cyc < 3000) begin
         rsp0_ready = ($urandom_range(0, 2) != 0);
         rsp1_ready = ($urandom_range(0, 2) != 0);
         #1;
         acc0 = req0_valid && req0_ready;
         acc1 = req1_valid && req1_ready;
         if (acc0) begin
            exp0 = alu_behavioural(req0_a, req0_b, req0_control);
            pend0 = 1;
         end
         if (acc1) begin
            exp1 = alu_behavioural(req1_a, req1_b, req1_control);
            pend1 = 1;
         end
         if (rsp0_valid && rsp0_ready) begin
            checks++;
            if (!pend0 || rsp1_valid !== 1'b0 ||
                {rsp0_overflow, rsp0_zero, rsp0_equal, rsp0_result} !== exp0) begin
               failures++;
               $display("FAIL rand_rsp0 #%0d got %h pend=%b v1=%b want %h",
                        got0, {rsp0_overflow, rsp0_zero, rsp0_equal, rsp0_result},
                        pend0, rsp1_valid, exp0);
            end
            pend0 = 0;
            got0++;
         end
         if (rsp1_valid && rsp1_ready) begin
            checks++;
            if (!pend1 || rsp0_valid !== 1'b0 ||
                {rsp1_overflow, rsp1_zero, rsp1_equal, rsp1_result} !== exp1) begin
               failures++;
               $display("FAIL rand_rsp1 #%0d got %h pend=%b v0=%b want %h",
                        got1, {rsp1_overflow, rsp1_zero, rsp1_equal, rsp1_result},
                        pend1, rsp0_valid, exp1);
            end
            pend1 = 0;
            got1++;
         end
         @(posedge clk);
         #1;
         if (acc0) begin
            sent0++;
            if (sent0 < 25) begin
               req0_a = $urandom;
               req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
               req0_control = alu_control_t'(4'($urandom_range(0, 9)));
            end else req0_valid = 0;
         end
         if (acc1) begin
            sent1++;
            if (sent1 < 25) begin
               req1_a = $urandom;
               req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
               req1_control = alu_control_t'(4'($urandom_range(0, 9)));
            end else req1_valid = 0;
         end
         cyc++;
      end
      checks++;
      if (got0 != 25 || got1 != 25) begin
         failures++;
         $display("FAIL rand_timeout got %0d/%0d responses want 25/25", got0, got1);
      end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_simultaneous();
      test_fairness();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
